// File: rtl/pcm_stream_dac.sv
// Streaming multichannel PCM player: frame FIFO, programmable sample-rate prescaler
// and one first-order delta-sigma 1-bit DAC per channel.
module pcm_stream_dac #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV        = 7000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [CHANNELS*WIDTH-1:0]       s_data,
    output logic [CHANNELS-1:0]             dac_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun,
    output logic [7:0]                      underrun_cnt,
    output logic                            sample_tick
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SW = WIDTH + 2;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(DIV - 1);
    localparam logic [AW:0]      LVL_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] MIDSCALE  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [SW-1:0]    SIGMA_RST = {2'b01, {WIDTH{1'b0}}};

    logic [CW-1:0]               r_cnt;
    logic                        r_tick;
    logic [CHANNELS*WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]               r_wptr;
    logic [AW-1:0]               r_rptr;
    logic [AW:0]                 r_level;
    logic                        r_underrun;
    logic [7:0]                  r_ucnt;
    logic [WIDTH-1:0]            r_held  [CHANNELS];
    logic [SW-1:0]               r_sigma [CHANNELS];
    logic [CHANNELS-1:0]         r_dac;

    logic                        w_tick;
    logic                        w_ready;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_empty;
    logic [CHANNELS*WIDTH-1:0]   w_frame;

    // Stream handshake: a frame transfers on every clock edge where s_valid and s_ready
    // are both high; s_ready depends only on the registered level, never on s_valid.
    assign w_ready = (r_level != LVL_FULL);
    assign w_push  = s_valid & w_ready;
    assign w_empty = (r_level == '0);
    assign w_tick  = enable & (r_cnt == CNT_LAST);
    assign w_pop   = w_tick & ~w_empty;
    assign w_frame = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_cnt      <= (!enable || w_tick) ? '0 : r_cnt + CW'(1);
            r_tick     <= w_tick;
            r_underrun <= w_tick & w_empty;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (AW + 1)'(1);
            end
            if (w_tick && w_empty && (r_ucnt != 8'hFF)) begin
                r_ucnt <= r_ucnt + 8'd1;
            end
        end
    end

    // Held samples change atomically across channels; the DAC loop sees them one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dac <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_held[k]  <= MIDSCALE;
                r_sigma[k] <= SIGMA_RST;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (!enable) begin
                    r_held[k] <= MIDSCALE;
                end else if (w_tick) begin
                    r_held[k] <= w_pop ? w_frame[k*WIDTH +: WIDTH] : MIDSCALE;
                end
                r_dac[k]   <= r_sigma[k][SW-1];
                r_sigma[k] <= r_sigma[k] + {2'b00, r_held[k]}
                            + {r_sigma[k][SW-1], r_sigma[k][SW-1], {WIDTH{1'b0}}};
            end
        end
    end

    assign s_ready      = w_ready;
    assign fifo_level   = r_level;
    assign dac_out      = r_dac;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;
    assign sample_tick  = r_tick;

endmodule

// File: tb/tb_pcm_stream_dac.sv
// Directed + randomized bench for pcm_stream_dac against a queue-based behavioural model.
module tb_pcm_stream_dac;

  localparam int W     = 8;
  localparam int CH    = 2;
  localparam int DEPTH = 16;
  localparam int DIV   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MID   = 1 << (W - 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              enable;
  logic              s_valid;
  logic              s_ready;
  logic [CH*W-1:0]   s_data;
  logic [CH-1:0]     dac_out;
  logic [LW-1:0]     fifo_level;
  logic              underrun;
  logic [7:0]        underrun_cnt;
  logic              sample_tick;

  pcm_stream_dac #(
    .WIDTH(W), .CHANNELS(CH), .FIFO_DEPTH(DEPTH), .DIV(DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dac_out(dac_out), .fifo_level(fifo_level), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .sample_tick(sample_tick)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [CH*W-1:0] exp_q[$];
  int              m_run;
  int              m_held  [CH];
  int              m_sigma [CH];
  logic [CH-1:0]   m_dac;
  bit              m_under;
  bit              m_tick;
  int              m_ucnt;
  int              ones    [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run   = 0;
    m_dac   = '0;
    m_under = 0;
    m_tick  = 0;
    m_ucnt  = 0;
    for (int k = 0; k < CH; k++) begin
      m_held[k]  = MID;
      m_sigma[k] = 1 << W;
    end
  endtask

  task automatic check_outputs();
    chk("dac_out", dac_out, m_dac);
    chk("fifo_level", fifo_level, exp_q.size());
    chk("s_ready", s_ready, (exp_q.size() != DEPTH));
    chk("underrun", underrun, m_under);
    chk("underrun_cnt", underrun_cnt, m_ucnt);
    chk("sample_tick", sample_tick, m_tick);
  endtask

  // One clock: predict from current inputs, clock, then compare.
  task automatic cycle();
    bit tick;
    bit push;
    bit nonempty;
    logic [CH*W-1:0] fr;
    push     = s_valid && (exp_q.size() != DEPTH);
    tick     = enable && (((m_run + 1) % DIV) == 0);
    nonempty = (exp_q.size() != 0);
    for (int k = 0; k < CH; k++) begin
      m_dac[k]   = (m_sigma[k] >= (2 << W));
      m_sigma[k] = m_sigma[k] + m_held[k] - (m_dac[k] ? (1 << W) : 0);
    end
    m_under = tick && !nonempty;
    if (m_under && m_ucnt < 255) m_ucnt++;
    if (!enable) begin
      for (int k = 0; k < CH; k++) m_held[k] = MID;
    end else if (tick) begin
      if (nonempty) begin
        fr = exp_q.pop_front();
        for (int k = 0; k < CH; k++) m_held[k] = int'(fr[k*W +: W]);
      end else begin
        for (int k = 0; k < CH; k++) m_held[k] = MID;
      end
    end
    if (push) exp_q.push_back(s_data);
    m_tick = tick;
    m_run  = enable ? m_run + 1 : 0;
    @(posedge clk);
    #1;
    check_outputs();
    for (int k = 0; k < CH; k++) ones[k] += int'(dac_out[k]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_ones();
    for (int k = 0; k < CH; k++) ones[k] = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    reset_n = 1'b1;
  endtask

  task automatic push_frames(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = CH*W'($urandom);
      cycle();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    clear_ones();
    do_reset();

    // idle playback: underrun every DIV cycles, midscale density
    enable = 1'b1;
    run(12);
    chk("ucnt_after_12", underrun_cnt, 3);
    clear_ones();
    run(256);
    chk_range("idle_density_ch0", ones[0], 127, 129);
    chk_range("idle_density_ch1", ones[1], 127, 129);

    // constant frame {ch1=40, ch0=C0} kept fed
    s_valid = 1'b1;
    s_data  = {8'h40, 8'hC0};
    run(8);
    clear_ones();
    run(256);
    chk_range("frame_density_ch0", ones[0], 191, 193);
    chk_range("frame_density_ch1", ones[1], 63, 65);
    s_valid = 1'b0;

    // fill while disabled, then first tick pops
    do_reset();
    enable = 1'b0;
    push_frames(16);
    chk("full_level", fifo_level, 16);
    chk("full_ready", s_ready, 0);
    enable = 1'b1;
    for (int i = 0; i < DIV + 2; i++) begin
      cycle();
      if (sample_tick) break;
    end
    chk("first_tick_seen", sample_tick, 1);
    chk("after_pop_level", fifo_level, 15);
    chk("after_pop_ready", s_ready, 1);
    run(6);

    // push coincident with tick at level 3
    do_reset();
    enable = 1'b0;
    push_frames(3);
    enable = 1'b1;
    run(DIV - 1);
    s_valid = 1'b1;
    s_data  = CH*W'($urandom);
    cycle();
    s_valid = 1'b0;
    chk("pushpop_tick", sample_tick, 1);
    chk("pushpop_level", fifo_level, 3);
    run(20);

    // push coincident with tick on empty FIFO
    do_reset();
    enable = 1'b1;
    run(DIV - 1);
    s_valid = 1'b1;
    s_data  = {8'hF0, 8'h11};
    cycle();
    s_valid = 1'b0;
    chk("empty_tick_underrun", underrun, 1);
    chk("empty_tick_level", fifo_level, 1);
    run(DIV);
    chk("next_tick_no_underrun", underrun, 0);
    chk("next_tick_level", fifo_level, 0);
    run(20);

    // asynchronous reset mid-period with 5 frames queued
    do_reset();
    enable = 1'b0;
    push_frames(5);
    enable = 1'b1;
    run(2);
    chk("pre_reset_level", fifo_level, 5);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_dac_out", dac_out, 0);
    chk("async_level", fifo_level, 0);
    chk("async_ready", s_ready, 1);
    chk("async_ucnt", underrun_cnt, 0);
    chk("async_tick", sample_tick, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(40);

    // randomized traffic: filling phase then draining phase
    for (int i = 0; i < 1000; i++) begin
      enable  = ($urandom_range(0, 63) != 0);
      s_valid = ($urandom_range(0, 1) == 0);
      s_data  = CH*W'($urandom);
      cycle();
    end
    for (int i = 0; i < 1000; i++) begin
      enable  = ($urandom_range(0, 63) != 0);
      s_valid = ($urandom_range(0, 7) == 0);
      s_data  = CH*W'($urandom);
      cycle();
    end

    // long starvation saturates the underrun counter
    enable  = 1'b1;
    s_valid = 1'b0;
    run(DIV * 270);
    chk("ucnt_saturated", underrun_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
